bus_conflict_table: RTL
=======================

# bus_conflict_table

Parametrised N-way skewed-associative table of in-flight block addresses for the bus controller. It generalises the fixed 2-way conflict table (way 1 indexed by lower XOR upper index) to NUM_WAYS ways with per-way skewed hashing. It also adds an occupancy counter, duplicate-insert stalling and remove-miss reporting. The bus controller checks every incoming dbus request against it, inserts on grant and removes on transaction completion.

## Interface
- BLOCK_ADDR_WIDTH, 29: block address width; must be ≥ 2*INDEX_BITS + 1.
- NUM_SETS, 8: sets per way; power of two; INDEX_BITS = $clog2(NUM_SETS).
- NUM_WAYS, 4: ways; 2 ≤ NUM_WAYS ≤ INDEX_BITS+1.
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset; asynchronous, active-high.
- check_valid  in  1  lookup request.
- check_block_addr  in  BLOCK_ADDR_WIDTH  address to look up.
- check_hit  out  1  combinational; check_valid and address present in any way.
- insert_valid  in  1  allocation request.
- insert_block_addr  in  BLOCK_ADDR_WIDTH  address to allocate.
- insert_ready  out  1  combinational; a candidate slot is free and the address is not already present.
- remove_valid  in  1  deallocation request.
- remove_block_addr  in  BLOCK_ADDR_WIDTH  address to free.
- remove_miss  out  1  registered; one-cycle pulse when a remove found no match.
- occupancy  out  $clog2(NUM_SETS*NUM_WAYS+1)  registered count of valid entries.
- full_sets  out  1  registered; occupancy == NUM_SETS*NUM_WAYS.

## Operation
- Hashing:
  - lower = addr[INDEX_BITS-1:0]; upper = addr[2*INDEX_BITS-1:INDEX_BITS].
  - Way 0 index = lower.
  - Way w ≥ 1 index = lower XOR rotl(upper, w-1), rotated within INDEX_BITS.
- Entry: valid bit plus the full block address. Matching compares the full address, never the tag alone.
- Lookup (check and insert paths): each way reads its own hashed index. Hit = OR over ways of (valid & addr equal).
- insert_ready = (some way's hashed entry is invalid) & !hit(insert_block_addr). Accept = insert_valid & insert_ready.
- Allocation goes to the lowest-numbered way whose hashed entry is invalid.
- Remove clears the matching valid entry. At most one can match, because duplicates are never inserted. No match: entry state unchanged and remove_miss=1 the next cycle.
- occupancy_next = occupancy + accept − (remove matched); accept plus matched remove in the same cycle leaves it unchanged.
- All combinational outputs are evaluated against registered state only; there is no bypass of same-cycle insert or remove.

## Timing
- Reset: all valid bits 0; occupancy 0; remove_miss 0; full_sets 0. RST asserted mid-operation clears the table immediately and asynchronously.
- check_hit and insert_ready have zero latency. An insert or remove becomes visible to check one cycle after the accepting edge.
- Simultaneous insert and remove of different addresses: both take effect at the same edge. The insert slot cannot collide with the removed slot, since the removed slot is valid.
- Simultaneous insert and remove of the same present address: the remove takes effect. insert_ready stays 0 that cycle (duplicate), so the insert is accepted next cycle if still valid.
- Insert while all candidate slots are valid: insert_ready=0, the requester holds insert_valid and the address stable, and no state changes.
- remove_valid asserted during reset release: ignored until RST is deasserted.

## Test plan
- Reset then check 0x0A -> check_hit=0, insert_ready=1, occupancy=0, remove_miss=0.
- Insert 0x0A (lower=2, upper=1) -> lands in way 0 idx 2. Next cycle check 0x0A hit=1, occupancy=1, and a re-insert of 0x0A gives insert_ready=0.
- Insert 0x0A, 0x4A, 0x8A, 0xCA in sequence -> ways 0..3 at idx 2, 3, 0, 6. Insert 0x10A then gives insert_ready=0 with occupancy=4.
- With the table full as above, assert remove 0x4A and insert 0x10A in the same cycle -> insert not accepted that cycle. The next cycle it is accepted into way 1 idx 3, and occupancy stays 4 after both edges.
- Remove 0x1FF while the table is empty -> remove_miss pulses for exactly one cycle and occupancy stays 0.
- Fill 8 addresses, then assert RST asynchronously mid-cycle -> occupancy=0 and all checks miss immediately, without waiting for CLK.

Source files
------------

// File: rtl/bus_conflict_table.sv
// Skewed-associative table of in-flight block addresses used by the bus
// controller to detect conflicting dbus requests. Each way hashes the block
// address to its own set index. Insert allocates into the lowest free way.
// Remove clears the matching entry. All lookups see registered state only.
module bus_conflict_table #(
    parameter int unsigned BLOCK_ADDR_WIDTH = 29,
    parameter int unsigned NUM_SETS         = 8,
    parameter int unsigned NUM_WAYS         = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       check_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0]                check_block_addr,
    output logic                                       check_hit,
    input  logic                                       insert_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0]                insert_block_addr,
    output logic                                       insert_ready,
    input  logic                                       remove_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0]                remove_block_addr,
    output logic                                       remove_miss,
    output logic [$clog2(NUM_SETS*NUM_WAYS+1)-1:0]     occupancy,
    output logic                                       full_sets
);

    localparam int unsigned INDEX_BITS  = $clog2(NUM_SETS);
    localparam int unsigned KEY_W       = 2 * INDEX_BITS;
    localparam int unsigned NUM_ENTRIES = NUM_SETS * NUM_WAYS;
    localparam int unsigned OCC_W       = $clog2(NUM_ENTRIES + 1);

    // Way 0 uses the lower index bits directly; way w XORs in the upper
    // index bits rotated left by w-1 so conflicting sets differ across ways.
    function automatic logic [INDEX_BITS-1:0] way_index(
        input logic [KEY_W-1:0] key,
        input int unsigned      w
    );
        logic [INDEX_BITS-1:0] lower;
        logic [INDEX_BITS-1:0] upper;
        logic [INDEX_BITS-1:0] rot;
        int unsigned           r;
        lower = key[INDEX_BITS-1:0];
        upper = key[KEY_W-1:INDEX_BITS];
        if (w == 0) begin
            return lower;
        end
        r   = (w - 1) % INDEX_BITS;
        rot = (upper << r) | (upper >> (INDEX_BITS - r));
        return lower ^ rot;
    endfunction

    logic [NUM_WAYS-1:0] chk_match;
    logic [NUM_WAYS-1:0] ins_match;
    logic [NUM_WAYS-1:0] ins_free;
    logic [NUM_WAYS-1:0] rem_match;
    logic [NUM_WAYS-1:0] alloc_oh;
    logic                accept;
    logic                rem_hit;
    logic [OCC_W-1:0]    occ_next;

    // Per-way storage, hashed lookups and slot updates.
    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        logic [NUM_SETS-1:0]         valid_q;
        logic [BLOCK_ADDR_WIDTH-1:0] addr_q [NUM_SETS];
        logic [INDEX_BITS-1:0]       chk_idx;
        logic [INDEX_BITS-1:0]       ins_idx;
        logic [INDEX_BITS-1:0]       rem_idx;

        assign chk_idx = way_index(check_block_addr[KEY_W-1:0], g);
        assign ins_idx = way_index(insert_block_addr[KEY_W-1:0], g);
        assign rem_idx = way_index(remove_block_addr[KEY_W-1:0], g);

        assign chk_match[g] = valid_q[chk_idx] && (addr_q[chk_idx] == check_block_addr);
        assign ins_match[g] = valid_q[ins_idx] && (addr_q[ins_idx] == insert_block_addr);
        assign ins_free[g]  = !valid_q[ins_idx];
        assign rem_match[g] = valid_q[rem_idx] && (addr_q[rem_idx] == remove_block_addr);

        // Valid bits: remove clears its matched slot, accept sets the allocated one.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
            end else begin
                if (remove_valid && rem_match[g]) begin
                    valid_q[rem_idx] <= 1'b0;
                end
                if (accept && alloc_oh[g]) begin
                    valid_q[ins_idx] <= 1'b1;
                end
            end
        end

        // Address payload is only meaningful under its valid bit, so no reset.
        always_ff @(posedge clk) begin
            if (accept && alloc_oh[g]) begin
                addr_q[ins_idx] <= insert_block_addr;
            end
        end
    end

    assign check_hit    = check_valid && (|chk_match);
    assign insert_ready = (|ins_free) && !(|ins_match);
    assign accept       = insert_valid && insert_ready;
    assign rem_hit      = remove_valid && (|rem_match);

    // Lowest-numbered free way wins the allocation.
    assign alloc_oh = ins_free & ~(ins_free - NUM_WAYS'(1));

    // Occupancy follows accepted inserts and matched removes.
    always_comb begin
        occ_next = occupancy;
        if (accept && !rem_hit) begin
            occ_next = occupancy + OCC_W'(1);
        end else if (!accept && rem_hit) begin
            occ_next = occupancy - OCC_W'(1);
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy   <= '0;
            full_sets   <= 1'b0;
            remove_miss <= 1'b0;
        end else begin
            occupancy   <= occ_next;
            full_sets   <= (occ_next == OCC_W'(NUM_ENTRIES));
            remove_miss <= remove_valid && !rem_hit;
        end
    end

endmodule
